// File: rtl/flag_pkg.sv
// flag_pkg: shared colour/entry types and stripe-height
// table builders for the programmable stripe flag renderer.
package flag_pkg;

  localparam int MAX_N = 8;

  typedef logic [5:0] color6_t;

  typedef struct packed {
    logic [1:0] level;
    color6_t    alt;
    color6_t    base;
  } stripe_entry_t;

  typedef logic [MAX_N-1:0][9:0] h_tab_t;

  function automatic h_tab_t base_tab(input int h);
    h_tab_t t;
    for (int n = 1; n <= MAX_N; n++) t[n-1] = 10'(h / n);
    return t;
  endfunction

  function automatic h_tab_t rem_tab(input int h);
    h_tab_t t;
    for (int n = 1; n <= MAX_N; n++) t[n-1] = 10'(h % n);
    return t;
  endfunction

endpackage

// File: rtl/flag_stripe_tracker.sv
// flag_stripe_tracker: follows pix_y line by line and yields
// the stripe index of the current line without any divider.
module flag_stripe_tracker
  import flag_pkg::*;
#(
  parameter int HEIGHT = 480
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_y,
  input  logic [3:0] n_act,
  output logic [2:0] stripe,
  output logic       frame_start,
  output logic       active
);

  localparam h_tab_t BASE_H = base_tab(HEIGHT);
  localparam h_tab_t REM_H  = rem_tab(HEIGHT);

  logic [9:0] prev_y, row_q, row_d, h_k;
  logic [2:0] acc_q, acc_d;
  logic [2:0] stripe_q, stripe_d, n_idx;
  logic [3:0] acc_sum;
  logic       act_q, act_d;
  logic       new_line, long_k, last_row;

  assign n_idx       = 3'(n_act - 4'd1);
  assign new_line    = pix_y != prev_y;
  assign frame_start = new_line && (pix_y == 10'd0);
  assign acc_sum     = {1'b0, acc_q} + 4'(REM_H[n_idx]);
  assign long_k      = acc_sum >= n_act;
  assign h_k         = BASE_H[n_idx] + {9'd0, long_k};
  assign last_row    = row_q == (h_k - 10'd1);

  // next stripe/row/acc state for the line now on pix_y
  always_comb begin
    row_d    = row_q;
    acc_d    = acc_q;
    stripe_d = stripe_q;
    act_d    = act_q;
    if (frame_start) begin
      row_d    = '0;
      acc_d    = '0;
      stripe_d = '0;
      act_d    = 1'b1;
    end else if (new_line) begin
      if (last_row) begin
        row_d = '0;
        acc_d = long_k ? 3'(acc_sum - n_act)
                       : acc_sum[2:0];
        if ({1'b0, stripe_q} < (n_act - 4'd1))
          stripe_d = stripe_q + 3'd1;
      end else begin
        row_d = row_q + 10'd1;
      end
    end
  end

  // line tracking state; all-ones prev_y lets y=0 start a frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_y   <= '1;
      row_q    <= '0;
      acc_q    <= '0;
      stripe_q <= '0;
      act_q    <= 1'b0;
    end else begin
      prev_y   <= pix_y;
      row_q    <= row_d;
      acc_q    <= acc_d;
      stripe_q <= stripe_d;
      act_q    <= act_d;
    end
  end

  assign stripe = stripe_d;
  assign active = act_d;

endmodule

// File: rtl/flag_stripes_prog.sv
// flag_stripes_prog: programmable horizontal-stripe flag with
// ordered dither; FLAG_MARQUEE_EN enables stripe rotation.
module flag_stripes_prog
  import flag_pkg::*;
#(
  parameter int MAX_STRIPES = 8,
  parameter int HEIGHT      = 480,
  parameter int WIDTH       = 640,
  parameter int ROT_FRAMES  = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [13:0] cfg_data,
  input  logic        cfg_n_we,
  input  logic [3:0]  cfg_n,
  output logic [5:0]  color
);

  if (MAX_STRIPES < 2 || MAX_STRIPES > MAX_N ||
      ROT_FRAMES < 1) begin : g_bad_param
    $error("flag_stripes_prog: bad parameter");
  end

  stripe_entry_t tbl [MAX_STRIPES];
  stripe_entry_t ent;
  logic [3:0] n_pend, n_pend_d, n_act, n_cur, idx_sum;
  logic [2:0] stripe, rot_d, idx;
  logic [1:0] bayer;
  logic       frame_start, active, vis, use_alt;

  flag_stripe_tracker #(
    .HEIGHT(HEIGHT)
  ) u_trk (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_y      (pix_y),
    .n_act      (n_act),
    .stripe     (stripe),
    .frame_start(frame_start),
    .active     (active)
  );

  // accept only legal stripe counts
  always_comb begin
    n_pend_d = n_pend;
    if (cfg_n_we && cfg_n != 4'd0 &&
        int'(cfg_n) <= MAX_STRIPES)
      n_pend_d = cfg_n;
  end

  assign n_cur = frame_start ? n_pend_d : n_act;

  // stripe table and stripe-count registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_STRIPES; i++)
        tbl[i] <= '0;
      tbl[0] <= '{level: 2'd0,
                  alt:   6'h3f,
                  base:  6'h3f};
      n_pend <= 4'd1;
      n_act  <= 4'd1;
    end else begin
      if (cfg_we && int'(cfg_addr) < MAX_STRIPES)
        tbl[cfg_addr] <= stripe_entry_t'(cfg_data);
      n_pend <= n_pend_d;
      if (frame_start)
        n_act <= n_pend_d;
    end
  end

`ifdef FLAG_MARQUEE_EN
  localparam int FW =
    (ROT_FRAMES > 1) ? $clog2(ROT_FRAMES) : 1;

  logic [FW-1:0] fcnt, fcnt_d;
  logic [2:0]    rot;
  logic          seen, seen_d, wrap;

  assign wrap = int'(fcnt) == ROT_FRAMES - 1;

  // rotation step once per ROT_FRAMES completed frames
  always_comb begin
    fcnt_d = fcnt;
    rot_d  = rot;
    seen_d = seen;
    if (frame_start) begin
      seen_d = 1'b1;
      if (seen)
        fcnt_d = wrap ? '0 : fcnt + FW'(1);
      if (n_pend_d != n_act)
        rot_d = '0;
      else if (seen && wrap)
        rot_d = ({1'b0, rot} + 4'd1 >= n_act)
                ? 3'd0 : rot + 3'd1;
    end
  end

  // marquee state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fcnt <= '0;
      rot  <= '0;
      seen <= 1'b0;
    end else begin
      fcnt <= fcnt_d;
      rot  <= rot_d;
      seen <= seen_d;
    end
  end
`else
  assign rot_d = 3'd0;
`endif

  assign idx_sum = {1'b0, stripe} + {1'b0, rot_d};
  assign idx     = (idx_sum >= n_cur)
                   ? 3'(idx_sum - n_cur)
                   : idx_sum[2:0];

  assign ent     = tbl[idx];
  assign bayer   = {pix_x[0] ^ pix_y[0], pix_y[0]};
  assign use_alt = bayer < ent.level;
  assign vis     = active &&
                   int'(pix_x) < WIDTH &&
                   int'(pix_y) < HEIGHT;

  // registered colour, one pixel behind the coordinates
  always_ff @(posedge clk) begin
    if (!rst_n)
      color <= '0;
    else if (vis)
      color <= use_alt ? ent.alt : ent.base;
    else
      color <= '0;
  end

endmodule

// File: tb/tb_flag_stripes_prog.sv
// tb_flag_stripes_prog: directed, table-driven checks of the
// stripe renderer (boundaries, dither, blanking, config).
module tb_flag_stripes_prog;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = 10'd500;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [13:0] cfg_data = '0;
  logic        cfg_n_we = 1'b0;
  logic [3:0]  cfg_n = '0;
  logic [5:0]  color;

  always #5 clk = ~clk;

  flag_stripes_prog #(
    .MAX_STRIPES(8),
    .HEIGHT     (480),
    .WIDTH      (640),
    .ROT_FRAMES (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pix_x   (pix_x),
    .pix_y   (pix_y),
    .cfg_we  (cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_n_we(cfg_n_we),
    .cfg_n   (cfg_n),
    .color   (color)
  );

  typedef struct {
    int         x;
    int         y;
    logic [5:0] exp;
  } vec_t;

  vec_t vt[$];
  vec_t t7[$];
  vec_t t5[$];
  int n_run = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [5:0] exp);
    n_run++;
    if (color !== exp) begin
      n_fail++;
      $display("FAIL %s: color=%b expected=%b",
               name, color, exp);
    end
  endtask

  task automatic pix(input int x, input int y);
    pix_x = 10'(x);
    pix_y = 10'(y);
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
    cfg_n_we = 1'b0;
  endtask

  task automatic wr_ent(input int a,
                        input logic [13:0] d);
    cfg_we   = 1'b1;
    cfg_addr = 3'(a);
    cfg_data = d;
    pix(int'(pix_x), int'(pix_y));
  endtask

  task automatic wr_n(input logic [3:0] n);
    cfg_n_we = 1'b1;
    cfg_n    = n;
    pix(int'(pix_x), int'(pix_y));
  endtask

  task automatic add(ref vec_t q[$], input int x,
                     input int y, input int e);
    vec_t v;
    v.x   = x;
    v.y   = y;
    v.exp = 6'(e);
    q.push_back(v);
  endtask

  task automatic run_frame(input int ny, input int cy,
                           input logic [3:0] cn);
    for (int y = 0; y < ny; y++) begin
      if (y == cy) begin
        cfg_n_we = 1'b1;
        cfg_n    = cn;
      end
      pix(0, y);
      foreach (vt[i]) begin
        if (vt[i].y == y) begin
          pix(vt[i].x, y);
          chk($sformatf("x%0d_y%0d", vt[i].x, y),
              vt[i].exp);
        end
      end
    end
  endtask

  initial begin
    // n=7 boundaries, entry k shows 10+k
    add(t7, 0, 0, 10);   add(t7, 0, 67, 10);
    add(t7, 0, 68, 11);  add(t7, 0, 136, 11);
    add(t7, 0, 137, 12); add(t7, 0, 204, 12);
    add(t7, 0, 205, 13); add(t7, 0, 273, 13);
    add(t7, 0, 274, 14); add(t7, 0, 341, 14);
    add(t7, 0, 342, 15); add(t7, 0, 410, 15);
    add(t7, 0, 411, 16); add(t7, 0, 479, 16);
    add(t7, 639, 479, 16);
    add(t7, 640, 100, 0);
    add(t7, 0, 480, 0);
    // n=5 boundaries
    add(t5, 0, 0, 10);   add(t5, 0, 95, 10);
    add(t5, 0, 96, 11);  add(t5, 0, 191, 11);
    add(t5, 0, 192, 12); add(t5, 0, 287, 12);
    add(t5, 0, 288, 13); add(t5, 0, 383, 13);
    add(t5, 0, 384, 14); add(t5, 0, 479, 14);
    add(t5, 0, 480, 0);

    pix(0, 500);
    pix(0, 500);
    chk("reset_color", 6'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 6; k++)
      wr_ent(k, {2'b00, 6'd0, 6'(10 + k)});
    cfg_n_we = 1'b1;
    cfg_n    = 4'd7;
    wr_ent(6, {2'b00, 6'd0, 6'd16});
    wr_ent(7, {2'b00, 6'd0, 6'd17});
    chk("idle_before_frame", 6'd0);

    vt = t7;
    run_frame(482, 200, 4'd5);
    vt = t5;
    run_frame(482, 10, 4'd0);
    run_frame(482, 10, 4'd9);
    run_frame(482, -1, 4'd0);

    // dither on a single stripe
    wr_ent(0, {2'd2, 6'b011011, 6'b101111});
    wr_n(4'd1);
    pix(0, 0); chk("dith_0_0", 6'b011011);
    pix(1, 0); chk("dith_1_0", 6'b101111);
    pix(1, 1); chk("dith_1_1", 6'b011011);
    pix(0, 1); chk("dith_0_1", 6'b101111);
    wr_ent(0, {2'd3, 6'b011011, 6'b101111});
    pix(1, 1); chk("lvl3_1_1", 6'b011011);
    pix(0, 1); chk("lvl3_0_1", 6'b101111);
    wr_ent(0, {2'd1, 6'b011011, 6'b101111});
    pix(1, 1); chk("lvl1_1_1", 6'b101111);

    // reset in the middle of a line
    pix(5, 1);
    rst_n = 1'b0;
    pix(6, 1); chk("rst_mid_line", 6'd0);
    rst_n = 1'b1;
    pix(7, 1); chk("idle_after_rst", 6'd0);
    pix(0, 0); chk("resume_white", 6'h3f);
    pix(3, 0); chk("resume_white2", 6'h3f);

`ifdef FLAG_MARQUEE_EN
    rst_n = 1'b0;
    pix(0, 500);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++)
      wr_ent(k, {2'b00, 6'd0, 6'(10 + k)});
    wr_n(4'd3);
    for (int f = 0; f < 8; f++) begin
      pix(0, 0);
      chk($sformatf("marquee_f%0d", f),
          6'(10 + ((f / 2) % 3)));
      pix(0, 1);
      pix(0, 2);
    end
`endif

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule
